// File: rtl/alu_stage.sv
// alu_stage: registered 8/16-bit ALU with a multi-cycle shift-add 8x8 multiplier
module alu_stage #(
    parameter int MUL_ITER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        wide,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_INC = 4'd12;
    localparam logic [3:0] OP_DEC = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam logic [3:0] OP_CMP = 4'd15;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]  state;
    logic        p_valid, p_wide, p_c;
    logic [3:0]  p_op;
    logic [15:0] p_a, p_b;
    logic [2:0]  cnt;
    logic [15:0] mc, acc, prod;
    logic [7:0]  mp;
    logic        is_mul, accept;
    logic [15:0] av, bv, bo, r, rm;
    logic [16:0] sum, dif;
    logic [3:0]  t;
    logic        ci, sa, sb, c, v;

    assign busy = (state == S_MUL);
    // A latched multiply has not raised busy yet, so it must still block a new request.
    assign is_mul = p_valid && (p_op == OP_MUL);
    assign accept = start && !busy && !is_mul;
    assign prod = acc + (mp[0] ? mc : 16'h0000);

    // single-cycle datapath on the latched operands; flags taken at the active width's top bit
    always_comb begin
        av = p_wide ? p_a : {8'h00, p_a[7:0]};
        bv = p_wide ? p_b : {8'h00, p_b[7:0]};
        t = p_wide ? 4'd15 : 4'd7;
        bo = (p_op == OP_INC || p_op == OP_DEC) ? 16'h0001 : bv;
        ci = (p_op == OP_ADC || p_op == OP_SBC) && p_c;
        sum = {1'b0, av} + {1'b0, bo} + {16'h0000, ci};
        dif = {1'b0, av} - {1'b0, bo} - {16'h0000, ci};
        sa = av[t];
        sb = bo[t];
        r = 16'h0000;
        c = 1'b0;
        v = 1'b0;
        case (p_op)
            4'd0, 4'd1, 4'd12: begin
                r = sum[15:0];
                c = sum[{1'b0, t} + 5'd1];
                v = (sa == sb) && (sum[{1'b0, t}] != sa);
            end
            4'd2, 4'd3, 4'd13, 4'd15: begin
                r = dif[15:0];
                c = dif[{1'b0, t} + 5'd1];
                v = (sa != sb) && (dif[{1'b0, t}] != sa);
            end
            4'd4: r = av & bv;
            4'd5: r = av | bv;
            4'd6: r = av ^ bv;
            4'd7: r = ~av;
            4'd8: begin
                r = {av[14:0], 1'b0};
                c = av[t];
            end
            4'd9: begin
                r = {1'b0, av[15:1]};
                c = av[0];
            end
            4'd10: begin
                r = {av[14:0], p_c};
                c = av[t];
            end
            4'd11: begin
                r = {1'b0, av[15:1]};
                r[t] = p_c;
                c = av[0];
            end
            default: r = 16'h0000;
        endcase
        rm = p_wide ? r : {8'h00, r[7:0]};
    end

    // capture an accepted request so later operand-bus changes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_op <= 4'd0;
            p_wide <= 1'b0;
            p_a <= 16'h0000;
            p_b <= 16'h0000;
            p_c <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_op <= op;
                p_wide <= wide;
                p_a <= a;
                p_b <= b;
                p_c <= flags[1];
            end
        end
    end

    // complete single-cycle ops, or step the shift-add multiplier one multiplier bit per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= 3'd0;
            mc <= 16'h0000;
            mp <= 8'h00;
            acc <= 16'h0000;
            result <= 16'h0000;
            flags <= 4'h0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_MUL) begin
                acc <= prod;
                mc <= {mc[14:0], 1'b0};
                mp <= {1'b0, mp[7:1]};
                cnt <= cnt + 3'd1;
                if (cnt == 3'(MUL_ITER - 1)) begin
                    state <= S_IDLE;
                    result <= prod;
                    flags <= {prod == 16'h0000, prod[15], prod[15:8] != 8'h00, 1'b0};
                    done <= 1'b1;
                end
            end else if (is_mul) begin
                state <= S_MUL;
                acc <= p_b[0] ? {8'h00, p_a[7:0]} : 16'h0000;
                mc <= {7'h00, p_a[7:0], 1'b0};
                mp <= {1'b0, p_b[7:1]};
                cnt <= 3'd1;
            end else if (p_valid) begin
                if (p_op != OP_CMP)
                    result <= rm;
                flags <= {rm == 16'h0000, rm[t], c, v};
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed vectors, multiply timing, reset abort and randomized checks against a reference model
module tb_alu_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic        wide = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;
    logic [15:0] m_res = 16'h0000;
    logic [3:0]  m_flg = 4'h0;

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [15:0] a, b, r;
        logic [3:0]  f;
    } vec_t;
    vec_t vt[21];

    always #5 clk = ~clk;

    alu_stage dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .wide(wide), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, id, act, exp);
        end
    endtask

    function automatic int sx(input int x, input int n);
        return (x >= (1 << (n - 1))) ? x - (1 << n) : x;
    endfunction

    // returns {result, Z, N, C, V} from the arithmetic meaning of each opcode
    function automatic logic [19:0] model(input logic [3:0] o, input logic w, input logic [15:0] x16,
                                          input logic [15:0] y16, input logic cin, input logic [15:0] prev);
        int n = w ? 16 : 8;
        int m = (1 << n) - 1;
        int x = int'(x16) & m;
        int y = int'(y16) & m;
        int k = (o == 4'd12 || o == 4'd13) ? 1 : y;
        int ci = (o == 4'd1 || o == 4'd3) ? int'(cin) : 0;
        int lo = -(1 << (n - 1));
        int hi = (1 << (n - 1)) - 1;
        int s = 0;
        int sv = 0;
        int res;
        logic c = 1'b0;
        logic v = 1'b0;
        case (o)
            4'd0, 4'd1, 4'd12: begin
                s = x + k + ci;
                sv = sx(x, n) + sx(k, n) + ci;
                c = s > m;
                v = sv < lo || sv > hi;
            end
            4'd2, 4'd3, 4'd13, 4'd15: begin
                s = x - k - ci;
                sv = sx(x, n) - sx(k, n) - ci;
                c = s < 0;
                v = sv < lo || sv > hi;
            end
            4'd4: s = x & y;
            4'd5: s = x | y;
            4'd6: s = x ^ y;
            4'd7: s = ~x;
            4'd8: begin s = x * 2; c = ((x >> (n - 1)) & 1) == 1; end
            4'd9: begin s = x / 2; c = (x % 2) == 1; end
            4'd10: begin s = x * 2 + int'(cin); c = ((x >> (n - 1)) & 1) == 1; end
            4'd11: begin s = x / 2 + (cin ? (1 << (n - 1)) : 0); c = (x % 2) == 1; end
            default: begin
                s = int'(x16[7:0]) * int'(y16[7:0]);
                n = 16;
                m = 65535;
                c = s > 255;
            end
        endcase
        res = s & m;
        return {(o == 4'd15) ? prev : 16'(res), res == 0, ((res >> (n - 1)) & 1) == 1, c, v};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic w, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic [3:0] ef, input int id);
        int bc = 0;
        int dc = 0;
        op = o; wide = w; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        for (int k = 1; k <= 12 && dc == 0; k++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (done) dc = k;
        end
        chk("done_latency", id, dc, (o == 4'd14) ? 8 : 1);
        chk("busy_cycles", id, bc, (o == 4'd14) ? 7 : 0);
        chk("result", id, result, er);
        chk("flags", id, flags, ef);
        @(posedge clk); #1;
        chk("done_single", id, done, 0);
        m_res = er;
        m_flg = ef;
    endtask

    initial begin
        logic [19:0] e;
        logic [3:0] o, po;
        logic w, pw, pc, pv, nc, ed;
        logic [15:0] x, y, pa, pb;
        int seen;

        vt[0]  = '{4'd0,  1'b0, 16'h00F0, 16'h0010, 16'h0000, 4'b1010};
        vt[1]  = '{4'd0,  1'b1, 16'h00F0, 16'h0010, 16'h0100, 4'b0000};
        vt[2]  = '{4'd2,  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
        vt[3]  = '{4'd15, 1'b1, 16'h0005, 16'h0005, 16'h7FFF, 4'b1000};
        vt[4]  = '{4'd0,  1'b1, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
        vt[5]  = '{4'd10, 1'b0, 16'h0081, 16'h0000, 16'h0002, 4'b0010};
        vt[6]  = '{4'd11, 1'b0, 16'h0001, 16'h0000, 16'h0080, 4'b0110};
        vt[7]  = '{4'd1,  1'b0, 16'h00FF, 16'h0000, 16'h0000, 4'b1010};
        vt[8]  = '{4'd3,  1'b1, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110};
        vt[9]  = '{4'd12, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101};
        vt[10] = '{4'd13, 1'b0, 16'h0000, 16'h0000, 16'h00FF, 4'b0110};
        vt[11] = '{4'd4,  1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100};
        vt[12] = '{4'd5,  1'b0, 16'h1234, 16'h0F0F, 16'h003F, 4'b0000};
        vt[13] = '{4'd6,  1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
        vt[14] = '{4'd7,  1'b0, 16'h0F0F, 16'h0000, 16'h00F0, 4'b0100};
        vt[15] = '{4'd8,  1'b1, 16'h8001, 16'h0000, 16'h0002, 4'b0010};
        vt[16] = '{4'd9,  1'b0, 16'h0301, 16'h0000, 16'h0000, 4'b1010};
        vt[17] = '{4'd2,  1'b0, 16'h0080, 16'h0001, 16'h007F, 4'b0001};
        vt[18] = '{4'd14, 1'b0, 16'h00FF, 16'h00FF, 16'hFE01, 4'b0110};
        vt[19] = '{4'd14, 1'b1, 16'h1203, 16'hAB05, 16'h000F, 4'b0000};
        vt[20] = '{4'd14, 1'b0, 16'h0000, 16'h00FF, 16'h0000, 4'b1000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 0, result, 0);
        chk("reset_flags", 0, flags, 0);
        chk("reset_busy", 0, busy, 0);
        chk("reset_done", 0, done, 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++)
            run_op(vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].r, vt[i].f, i);

        // start held while multiplying is ignored; start in the done cycle is accepted
        op = 4'd14; wide = 1'b0; a = 16'h0034; b = 16'h0012; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_busy_n", 0, busy, 0);
        @(posedge clk); #1;
        chk("hold_busy_n1", 0, busy, 1);
        start = 1'b1; op = 4'd0; wide = 1'b1; a = 16'h1111; b = 16'h2222;
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            chk("hold_busy", k, busy, 1);
            chk("hold_done", k, done, 0);
            chk("hold_result", k, result, m_res);
        end
        @(posedge clk); #1;
        chk("hold_mul_done", 8, done, 1);
        chk("hold_mul_busy", 8, busy, 0);
        chk("hold_mul_result", 8, result, 16'h03A8);
        chk("hold_mul_flags", 8, flags, 4'b0010);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_gap_done", 9, done, 0);
        @(posedge clk); #1;
        chk("hold_add_done", 10, done, 1);
        chk("hold_add_result", 10, result, 16'h3333);
        chk("hold_add_flags", 10, flags, 4'b0000);
        @(posedge clk); #1;
        chk("hold_add_single", 11, done, 0);

        // reset in the middle of a multiply aborts it without a done pulse
        op = 4'd14; a = 16'h00FF; b = 16'h00FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_result", 0, result, 0);
        chk("abort_flags", 0, flags, 0);
        chk("abort_busy", 0, busy, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", 0, seen, 0);
        m_res = 16'h0000;
        m_flg = 4'h0;

        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 15));
            w = 1'($urandom);
            x = 16'($urandom);
            y = 16'($urandom);
            e = model(o, w, x, y, m_flg[1], m_res);
            run_op(o, w, x, y, e[19:4], e[3:0], 100 + i);
        end

        // back-to-back single-cycle ops; each latches the carry visible in its accept cycle
        pv = 1'b0; po = 4'd0; pw = 1'b0; pa = 16'h0; pb = 16'h0; pc = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            if (t < 40) begin
                o = 4'($urandom_range(0, 14));
                op = (o == 4'd14) ? 4'd15 : o;
                wide = 1'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            nc = m_flg[1];
            ed = pv;
            if (pv) begin
                e = model(po, pw, pa, pb, pc, m_res);
                m_res = e[19:4];
                m_flg = e[3:0];
            end
            pv = (t < 40); po = op; pw = wide; pa = a; pb = b; pc = nc;
            #1;
            chk("b2b_done", t, done, ed);
            if (ed) begin
                chk("b2b_result", t, result, m_res);
                chk("b2b_flags", t, flags, m_flg);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
